stage_m: RTL and testbench

STAGE_M -- requirements
Module: stage_m

---
 rtl/stage_m_pkg.sv | 35 +++
 rtl/stage_m_if.sv | 15 +
 rtl/stage_m_load_ext.sv | 28 ++
 rtl/stage_m.sv | 94 +++++++++
 tb/tb_stage_m.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/stage_m_pkg.sv
// rtl/stage_m_pkg.sv - memory-op and FSM encodings shared by the M-stage memory controller
package stage_m_pkg;

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LW   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LHU  = 4'd3;
  localparam logic [3:0] MEM_LB   = 4'd4;
  localparam logic [3:0] MEM_LBU  = 4'd5;
  localparam logic [3:0] MEM_SW   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SB   = 4'd8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LW) && (op <= MEM_LBU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SW) && (op <= MEM_SB);
  endfunction

  function automatic logic [3:0] byte_enables(input logic [3:0] op, input logic [1:0] a);
    case (op)
      MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU, MEM_SW: byte_enables = 4'hF;
      MEM_SH:  byte_enables = a[1] ? 4'hC : 4'h3;
      MEM_SB:  byte_enables = 4'b0001 << a;
      default: byte_enables = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/stage_m_if.sv
// rtl/stage_m_if.sv - data-memory request/acknowledge bus between the M stage and memory
interface stage_m_if;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_be, dm_wdata, input dm_ack, dm_rdata);
  modport slave  (input dm_req, dm_we, dm_addr, dm_be, dm_wdata, output dm_ack, dm_rdata);

endinterface

// File: rtl/stage_m_load_ext.sv
// rtl/stage_m_load_ext.sv - selects the addressed byte/half of a read word and extends it
module load_ext
  import stage_m_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = rdata >> {byte_off, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: result = {16'h0000, half_sel};
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {24'h000000, byte_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/stage_m.sv
// rtl/stage_m.sv - M-stage memory access controller: one held request per load/store, stalls until ack
module stage_m
  import stage_m_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_M,
  input  logic [3:0]  MemOp_M,
  input  logic [31:0] C_M,
  input  logic [31:0] WD_M,
  stage_m_if.master   dm,
  output logic [31:0] RD_M,
  output logic        mem_busy,
  output logic        addr_err
);

  logic [1:0]  state;
  logic [31:0] addr_q;
  logic [3:0]  op_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] ext_data;
  logic        is_ls;
  logic        aligned;
  logic        start;
  logic [31:0] wdata_d;

  always_comb begin
    is_ls = is_load(MemOp_M) || is_store(MemOp_M);
    case (MemOp_M)
      MEM_LW, MEM_SW:          aligned = (C_M[1:0] == 2'b00);
      MEM_LH, MEM_LHU, MEM_SH: aligned = ~C_M[0];
      default:                 aligned = 1'b1;
    endcase
    start    = valid_M && is_ls && aligned;
    addr_err = valid_M && is_ls && !aligned;
    mem_busy = ((state == ST_IDLE) && start) || (state == ST_REQ);
    case (MemOp_M)
      MEM_SW:  wdata_d = WD_M;
      MEM_SH:  wdata_d = {2{WD_M[15:0]}};
      MEM_SB:  wdata_d = {4{WD_M[7:0]}};
      default: wdata_d = 32'h0;
    endcase
  end

  // Request fields come only from the latched copy so they stay stable while memory stalls.
  always_comb begin
    dm.dm_req   = (state == ST_REQ);
    dm.dm_we    = (state == ST_REQ) && is_store(op_q);
    dm.dm_be    = (state == ST_REQ) ? be_q : 4'h0;
    dm.dm_addr  = {addr_q[31:2], 2'b00};
    dm.dm_wdata = wdata_q;
  end

  load_ext u_load_ext (
    .op       (op_q),
    .byte_off (addr_q[1:0]),
    .rdata    (dm.dm_rdata),
    .result   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= 32'h0;
      op_q    <= MEM_NONE;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      RD_M    <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= C_M;
            op_q    <= MemOp_M;
            be_q    <= byte_enables(MemOp_M, C_M[1:0]);
            wdata_q <= wdata_d;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dm.dm_ack) begin
            if (is_load(op_q)) RD_M <= ext_data;
            state <= ST_DONE;
          end
        end
        // The finished instruction is still sitting in M here; skipping start avoids re-issuing it.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_m.sv
// tb/tb_stage_m.sv - directed self-checking bench for stage_m
module tb_stage_m;
  import stage_m_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_M;
  logic [3:0]  MemOp_M;
  logic [31:0] C_M;
  logic [31:0] WD_M;
  logic [31:0] RD_M;
  logic        mem_busy;
  logic        addr_err;

  stage_m_if dm ();

  stage_m dut (
    .clk      (clk),
    .reset    (reset),
    .valid_M  (valid_M),
    .MemOp_M  (MemOp_M),
    .C_M      (C_M),
    .WD_M     (WD_M),
    .dm       (dm.master),
    .RD_M     (RD_M),
    .mem_busy (mem_busy),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          r_busy;
  int          r_reqs;
  logic        r_stable;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one op, acks after 'delay' extra REQ cycles and returns in its DONE cycle with the op still held.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, input logic [31:0] rdata);
    bit done = 0;
    int waited = 0;
    @(negedge clk);
    valid_M = 1'b1; MemOp_M = op; C_M = addr; WD_M = wd;
    r_busy = 0; r_reqs = 0; r_stable = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (i == 0) check("no_req_in_issue_cycle", {31'b0, dm.dm_req}, 32'd0);
      if (mem_busy) r_busy++;
      if (dm.dm_req) begin
        if (r_reqs == 0) begin
          r_be = dm.dm_be; r_addr = dm.dm_addr; r_wdata = dm.dm_wdata; r_we = dm.dm_we;
        end else if (dm.dm_be != r_be || dm.dm_addr != r_addr ||
                     dm.dm_wdata != r_wdata || dm.dm_we != r_we) begin
          r_stable = 1'b0;
        end
        r_reqs++;
        if (waited == delay) begin
          dm.dm_ack = 1'b1; dm.dm_rdata = rdata;
        end
        waited++;
      end else if (r_reqs > 0) begin
        done = 1;
      end
      if (!done) begin
        @(posedge clk);
        #1 dm.dm_ack = 1'b0;
        @(negedge clk);
      end
    end
    check("op_completed", {31'b0, done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; valid_M = 1'b0; MemOp_M = MEM_NONE; C_M = 32'h0; WD_M = 32'h0;
    dm.dm_ack = 1'b0; dm.dm_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_rd", RD_M, 32'h0);
    check("reset_req", {31'b0, dm.dm_req}, 32'd0);
    check("reset_busy", {31'b0, mem_busy}, 32'd0);
    check("reset_be", {28'b0, dm.dm_be}, 32'h0);

    run_op(MEM_LW, 32'h100, 32'h0, 0, 32'h8000_00FF);
    check("lw_be", {28'b0, r_be}, 32'hF);
    check("lw_addr", r_addr, 32'h100);
    check("lw_we", {31'b0, r_we}, 32'd0);
    check("lw_rd", RD_M, 32'h8000_00FF);
    check("lw_busy_cycles", r_busy, 32'd2);
    check("lw_reqs", r_reqs, 32'd1);

    run_op(MEM_LB, 32'h103, 32'h0, 0, 32'h80AA_BBCC);
    check("lb_be", {28'b0, r_be}, 32'hF);
    check("lb_addr", r_addr, 32'h100);
    check("lb_rd", RD_M, 32'hFFFF_FF80);
    run_op(MEM_LBU, 32'h103, 32'h0, 0, 32'h80AA_BBCC);
    check("lbu_rd", RD_M, 32'h0000_0080);
    run_op(MEM_LH, 32'h102, 32'h0, 0, 32'h80AA_BBCC);
    check("lh_rd", RD_M, 32'hFFFF_80AA);
    run_op(MEM_LHU, 32'h100, 32'h0, 0, 32'h80AA_BBCC);
    check("lhu_rd", RD_M, 32'h0000_BBCC);

    run_op(MEM_SH, 32'h102, 32'h1234_5678, 3, 32'hDEAD_BEEF);
    check("sh_be", {28'b0, r_be}, 32'hC);
    check("sh_wdata", r_wdata, 32'h5678_5678);
    check("sh_we", {31'b0, r_we}, 32'd1);
    check("sh_req_cycles", r_reqs, 32'd4);
    check("sh_stable", {31'b0, r_stable}, 32'd1);
    check("sh_rd_unchanged", RD_M, 32'h0000_BBCC);
    check("sh_busy_cycles", r_busy, 32'd5);

    run_op(MEM_SB, 32'h201, 32'h0000_00A5, 1, 32'h0);
    check("sb_be", {28'b0, r_be}, 32'h2);
    check("sb_wdata", r_wdata, 32'hA5A5_A5A5);
    check("sb_addr", r_addr, 32'h200);
    run_op(MEM_SW, 32'h208, 32'hCAFE_F00D, 0, 32'h0);
    check("sw_be", {28'b0, r_be}, 32'hF);
    check("sw_wdata", r_wdata, 32'hCAFE_F00D);

    @(negedge clk);
    valid_M = 1'b1; MemOp_M = MEM_LW; C_M = 32'h101;
    #1;
    check("lw_mis_err", {31'b0, addr_err}, 32'd1);
    check("lw_mis_busy", {31'b0, mem_busy}, 32'd0);
    @(posedge clk);
    #1;
    check("lw_mis_req", {31'b0, dm.dm_req}, 32'd0);
    @(negedge clk);
    MemOp_M = MEM_SH; C_M = 32'h103;
    #1;
    check("sh_mis_err", {31'b0, addr_err}, 32'd1);
    valid_M = 1'b0;
    #1;
    check("no_valid_err", {31'b0, addr_err}, 32'd0);

    @(negedge clk);
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 dm.dm_ack = 1'b0;
    check("idle_ack_rd", RD_M, 32'h0000_BBCC);
    check("idle_ack_req", {31'b0, dm.dm_req}, 32'd0);

    @(negedge clk);
    valid_M = 1'b1; MemOp_M = MEM_LW; C_M = 32'h300;
    @(negedge clk);
    check("rst_mid_req1", {31'b0, dm.dm_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1; valid_M = 1'b0; MemOp_M = MEM_NONE;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst_mid_req", {31'b0, dm.dm_req}, 32'd0);
    check("rst_mid_rd", RD_M, 32'h0);
    check("rst_mid_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
    @(negedge clk);
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'h1234_5678;
    @(posedge clk);
    #1 dm.dm_ack = 1'b0;
    check("late_ack_rd", RD_M, 32'h0);
    check("late_ack_req", {31'b0, dm.dm_req}, 32'd0);

    run_op(MEM_SB, 32'h200, 32'h0000_0011, 0, 32'h0);
    check("b2b_sb_reqs", r_reqs, 32'd1);
    check("b2b_sb_be", {28'b0, r_be}, 32'h1);
    run_op(MEM_LW, 32'h204, 32'h0, 0, 32'h0BAD_F00D);
    check("b2b_lw_reqs", r_reqs, 32'd1);
    check("b2b_lw_addr", r_addr, 32'h204);
    check("b2b_lw_rd", RD_M, 32'h0BAD_F00D);
    check("b2b_lw_busy", r_busy, 32'd2);

    @(negedge clk);
    valid_M = 1'b0; MemOp_M = MEM_NONE;
    repeat (3) @(negedge clk);
    check("final_idle_req", {31'b0, dm.dm_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
